// File: rtl/satu_pkg.sv
// Shared encodings and lane-geometry helpers for the packed-SIMD saturating adder.
package satu_pkg;

    localparam logic [1:0] MODE_WRAP  = 2'b00;
    localparam logic [1:0] MODE_SAT8  = 2'b01;
    localparam logic [1:0] MODE_SAT16 = 2'b10;
    localparam logic [1:0] MODE_SATW  = 2'b11;

    localparam int BYTE_W    = 8;
    localparam int DEF_W     = 32;
    localparam int DEF_BYTES = DEF_W / BYTE_W;

    // Byte count of one lane for a given mode; wrap and full-word share one W-bit lane.
    function automatic int lane_bytes(input logic [1:0] mode, input int nbytes);
        case (mode)
            MODE_SAT8:  return 1;
            MODE_SAT16: return 2;
            default:    return nbytes;
        endcase
    endfunction

    // Index of the most significant byte of the lane holding byte idx.
    function automatic int lane_msb(input logic [1:0] mode, input int idx, input int nbytes);
        int m;
        m = idx - (idx % lane_bytes(mode, nbytes)) + lane_bytes(mode, nbytes) - 1;
        if (m >= nbytes) m = nbytes - 1;
        return m;
    endfunction

    // True when byte idx starts a lane, i.e. takes the external carry-in.
    function automatic logic lane_lsb(input logic [1:0] mode, input int idx, input int nbytes);
        return (idx % lane_bytes(mode, nbytes)) == 0;
    endfunction

endpackage

// File: rtl/satu_lane_sel.sv
// One byte of the saturation select: substitutes the clamp pattern for the sum byte.
module satu_lane_sel
    import satu_pkg::*;
(
    input  logic        sign_a,
    input  logic [7:0]  sum,
    input  logic        is_msb,
    input  logic        v,
    input  logic        en,
    output logic [7:0]  res,
    output logic        sat
);

    // Positive overflow clamps to 0x7F..FF, negative to 0x80..00; the lane MSB byte carries the sign bit.
    always_comb begin
        sat = v && en;
        res = sum;
        if (sat) begin
            if (sign_a) res = is_msb ? 8'h80 : 8'h00;
            else        res = is_msb ? 8'h7F : 8'hFF;
        end
    end

endmodule

// File: rtl/satu_simd_pipe.sv
// Two-stage packed-SIMD saturating add/subtract with valid/ready flow and saturation status.
module satu_simd_pipe
    import satu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             sub,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [W/8-1:0]   lane_sat,
    output logic             sat_sticky,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] sat_count
);

    localparam int NB = W / BYTE_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic          adv1, adv2;
    logic          vld_p1, vld_p2;
    logic [NB-1:0] lsb_vec;
    logic [W-1:0]  sum_n;
    logic [NB-1:0] amsb_n, bmsb_n;
    logic [7:0]    bb;
    logic          c;

    logic [W-1:0]  sum_p1;
    logic [NB-1:0] amsb_p1, bmsb_p1;
    logic [1:0]    mode_p1;

    logic [W-1:0]  res_n;
    logic [NB-1:0] sat_n;

    assign adv2      = !vld_p2 || out_ready;
    assign adv1      = !vld_p1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_p2;

    for (genvar i = 0; i < NB; i++) begin : g_lsb
        localparam logic L16 = lane_lsb(MODE_SAT16, i, NB);
        localparam logic LW  = lane_lsb(MODE_SATW, i, NB);
        assign lsb_vec[i] = (mode == MODE_SAT8) ? 1'b1 : (mode == MODE_SAT16) ? L16 : LW;
    end

    // Byte-sliced adder: carry ripples between bytes except where a lane starts.
    always_comb begin
        c      = 1'b0;
        bb     = '0;
        sum_n  = '0;
        amsb_n = '0;
        bmsb_n = '0;
        for (int i = 0; i < NB; i++) begin
            bb = sub ? ~b[i*8 +: 8] : b[i*8 +: 8];
            if (lsb_vec[i]) c = sub;
            {c, sum_n[i*8 +: 8]} = {1'b0, a[i*8 +: 8]} + {1'b0, bb} + {8'b0, c};
            amsb_n[i] = a[i*8+7];
            bmsb_n[i] = bb[7];
        end
    end

    // ---- stage 1 boundary ----
    // Stage-1 valid advances whenever the stage can move.
    always_ff @(posedge clk) begin
        if (rst)       vld_p1 <= 1'b0;
        else if (adv1) vld_p1 <= in_valid;
    end

    // Stage-1 data loads only on an accepted beat, otherwise holds.
    always_ff @(posedge clk) begin
        if (in_valid && adv1) begin
            sum_p1  <= sum_n;
            amsb_p1 <= amsb_n;
            bmsb_p1 <= bmsb_n;
            mode_p1 <= mode;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_sel
        localparam int M8  = lane_msb(MODE_SAT8, i, NB);
        localparam int M16 = lane_msb(MODE_SAT16, i, NB);
        localparam int MW  = lane_msb(MODE_SATW, i, NB);
        localparam logic I16 = (M16 == i);
        localparam logic IW  = (MW == i);
        logic sa, sb, ss, msb, v;
        assign sa  = (mode_p1 == MODE_SAT8) ? amsb_p1[M8] :
                     (mode_p1 == MODE_SAT16) ? amsb_p1[M16] : amsb_p1[MW];
        assign sb  = (mode_p1 == MODE_SAT8) ? bmsb_p1[M8] :
                     (mode_p1 == MODE_SAT16) ? bmsb_p1[M16] : bmsb_p1[MW];
        assign ss  = (mode_p1 == MODE_SAT8) ? sum_p1[M8*8+7] :
                     (mode_p1 == MODE_SAT16) ? sum_p1[M16*8+7] : sum_p1[MW*8+7];
        assign msb = (mode_p1 == MODE_SAT8) ? 1'b1 : (mode_p1 == MODE_SAT16) ? I16 : IW;
        assign v   = (sa == sb) && (ss != sa);

        satu_lane_sel u_sel (
            .sign_a (sa),
            .sum    (sum_p1[i*8 +: 8]),
            .is_msb (msb),
            .v      (v),
            .en     (mode_p1 != MODE_WRAP),
            .res    (res_n[i*8 +: 8]),
            .sat    (sat_n[i])
        );
    end

    // ---- stage 2 boundary ----
    // Output register holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            result   <= '0;
            lane_sat <= '0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result   <= res_n;
                lane_sat <= sat_n;
            end
        end
    end

    // Saturation status updates on accepted results; a saturated accept beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_sticky <= 1'b0;
            sat_count  <= '0;
        end else if (vld_p2 && out_ready && (|lane_sat)) begin
            sat_sticky <= 1'b1;
            if (clr_sticky)      sat_count <= CNT_ONE;
            else if (!(&sat_count)) sat_count <= sat_count + CNT_ONE;
        end else if (clr_sticky) begin
            sat_sticky <= 1'b0;
            sat_count  <= '0;
        end
    end

endmodule

// File: tb/tb_satu_simd_pipe.sv
// Scoreboard bench for satu_simd_pipe: directed vectors with hand-computed results.
module tb_satu_simd_pipe;
    import satu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [1:0]  mode;
    logic [3:0]  lane_sat;
    logic        sat_sticky, clr_sticky;
    logic [7:0]  sat_count;

    logic        iv2, ir2, ov2, st2;
    logic [31:0] res2;
    logic [3:0]  ls2;
    logic [1:0]  cnt2;

    typedef struct { logic [31:0] r; logic [3:0] l; } exp_t;
    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    satu_simd_pipe #(.W(32), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .lane_sat(lane_sat), .sat_sticky(sat_sticky), .clr_sticky(clr_sticky),
        .sat_count(sat_count)
    );

    satu_simd_pipe #(.W(32), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a(32'h7F00_0000), .b(32'h0100_0000), .sub(1'b0), .mode(MODE_SAT8),
        .out_valid(ov2), .out_ready(1'b1), .result(res2),
        .lane_sat(ls2), .sat_sticky(st2), .clr_sticky(1'b0),
        .sat_count(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic [1:0] tm, input logic [31:0] er, input logic [3:0] el);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        a = ta; b = tb; sub = ts; mode = tm; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck low for beat a=0x%0h", ta);
        end else begin
            e.r = er; e.l = el;
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk); #3; n++;
        end
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d results never appeared", q.size());
        end
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output: result=0x%0h with empty scoreboard", result);
                end else if (out_ready) begin
                    e = q.pop_front();
                    chk("result", result, e.r);
                    chk("lane_sat", 32'(lane_sat), 32'(e.l));
                end else begin
                    chk("stall_result", result, q[0].r);
                    chk("stall_lane_sat", 32'(lane_sat), 32'(q[0].l));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; mode = MODE_WRAP;
        out_ready = 1'b1; clr_sticky = 1'b0; iv2 = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_lane_sat", 32'(lane_sat), 32'd0);
        chk("rst_sticky", 32'(sat_sticky), 32'd0);
        chk("rst_count", 32'(sat_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Byte lanes: top byte overflows, 0x7F+0x80 does not; check 2-cycle latency.
        send(32'h7F7F_0102, 32'h0180_0101, 1'b0, MODE_SAT8, 32'h7FFF_0203, 4'b1000);
        idle();
        #1 chk("lat1_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 chk("lat1_cycle2", 32'(out_valid), 32'd1);

        send(32'h8000_0000, 32'h0100_0000, 1'b1, MODE_SAT8, 32'h8000_0000, 4'b1000);
        send(32'h8000_0000, 32'h0100_0000, 1'b1, MODE_WRAP, 32'h7F00_0000, 4'b0000);
        send(32'h7FFF_8000, 32'h0001_FFFF, 1'b0, MODE_SAT16, 32'h7FFF_8000, 4'b1111);
        // Full word: 0x7FFF8000+0x0001FFFF = 0x80017FFF overflows positive.
        send(32'h7FFF_8000, 32'h0001_FFFF, 1'b0, MODE_SATW, 32'h7FFF_FFFF, 4'b1111);
        send(32'h7FFF_8000, 32'h0001_FFFF, 1'b0, MODE_WRAP, 32'h8001_7FFF, 4'b0000);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, MODE_SATW, 32'h8000_0000, 4'b1111);
        idle();
        drain();

        // Backpressure: consumer stalls while four beats stream in.
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                send(32'h0102_0304, 32'h1010_1010, 1'b0, MODE_SAT8, 32'h1112_1314, 4'b0000);
                send(32'h7F00_0000, 32'h0100_0000, 1'b0, MODE_SAT8, 32'h7F00_0000, 4'b1000);
                send(32'h0005_0003, 32'h0001_0001, 1'b1, MODE_SAT16, 32'h0004_0002, 4'b0000);
                send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_WRAP, 32'h0000_0000, 4'b0000);
            end
            begin
                repeat (3) @(negedge clk);
                #1 chk("bp_in_ready_full", 32'(in_ready), 32'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Status: clear, then three saturated accepts.
        @(negedge clk); clr_sticky = 1'b1;
        @(negedge clk); clr_sticky = 1'b0;
        #1;
        chk("clr_count", 32'(sat_count), 32'd0);
        chk("clr_sticky", 32'(sat_sticky), 32'd0);
        repeat (3) send(32'h7F00_0000, 32'h0100_0000, 1'b0, MODE_SAT8, 32'h7F00_0000, 4'b1000);
        idle();
        drain();
        @(negedge clk); #1;
        chk("sat3_count", 32'(sat_count), 32'd3);
        chk("sat3_sticky", 32'(sat_sticky), 32'd1);

        // Clear coinciding with a saturated accept: set wins, count restarts at 1.
        send(32'h7F00_0000, 32'h0100_0000, 1'b0, MODE_SAT8, 32'h7F00_0000, 4'b1000);
        idle();
        @(negedge clk);
        #1 chk("clr_sat_ov", 32'(out_valid), 32'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        #1;
        chk("clr_sat_count", 32'(sat_count), 32'd1);
        chk("clr_sat_sticky", 32'(sat_sticky), 32'd1);
        @(negedge clk); clr_sticky = 1'b1;
        @(negedge clk); clr_sticky = 1'b0;
        #1;
        chk("clr2_count", 32'(sat_count), 32'd0);
        chk("clr2_sticky", 32'(sat_sticky), 32'd0);

        // Unsaturated accepts leave status alone.
        send(32'h0102_0304, 32'h1010_1010, 1'b0, MODE_SAT8, 32'h1112_1314, 4'b0000);
        idle();
        drain();
        @(negedge clk); #1;
        chk("nosat_count", 32'(sat_count), 32'd0);

        // Reset with both stages full discards the beats.
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h7F00_0000, 32'h0100_0000, 1'b0, MODE_SAT8, 32'h7F00_0000, 4'b1000);
        send(32'h7F00_0000, 32'h0100_0000, 1'b0, MODE_SAT8, 32'h7F00_0000, 4'b1000);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        #1 chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_count", 32'(sat_count), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        send(32'h0102_0304, 32'h1010_1010, 1'b0, MODE_SAT8, 32'h1112_1314, 4'b0000);
        idle();
        #1 chk("lat2_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 chk("lat2_cycle2", 32'(out_valid), 32'd1);
        drain();

        // Narrow counter saturates at all-ones after five saturated accepts.
        @(negedge clk); iv2 = 1'b1;
        repeat (5) @(negedge clk);
        iv2 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("cnt2_hold", 32'(cnt2), 32'd3);
        chk("cnt2_sticky", 32'(st2), 32'd1);
        chk("cnt2_result", res2, 32'h7F00_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
